fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Instruction-fetch sequencer for the RV64I pipeline's IF stage.
//  - Owns the fetch PC and drives the combinational instruction-memory read port.
//  - Buffers fetched {pc, instr} pairs in a small FIFO.
//  - Presents them to the IF/ID register through a valid/ready handshake.
//  - Handles branch/jump redirects from EX and a halt request.
// PARAMETERS
//  XLEN        64             address/PC width
//  RESET_PC    64'h0          fetch PC loaded on reset
//  FIFO_DEPTH  2              fetch buffer entries; power of two, >=2
// PORTS
//  clk             in   1     clock, all state on rising edge
//  rst_n           in   1     asynchronous active-low reset
//  imem_addr       out  XLEN  byte address to instruction memory (= fetch_pc)
//  imem_instr      in   32    instruction returned combinationally for imem_addr
//  redirect_valid  in   1     EX requests PC redirect this cycle
//  redirect_pc     in   XLEN  redirect target
//  halt            in   1     stop issuing new fetches (level)
//  if_valid        out  1     buffered instruction available
//  if_ready        in   1     decode accepts head entry
//  if_instr        out  32    head-entry instruction
//  if_pc           out  XLEN  head-entry PC
//  fetch_state     out  2     current FSM state (debug/visibility)
// BEHAVIOUR
//  - Reset (async, rst_n=0): fetch_pc=RESET_PC, FIFO empty, state=FETCH; if_valid=0, if_instr=NOP (32'h00000013), if_pc=0.
//  - imem_addr = fetch_pc, purely combinational; memory returns the instruction in the same cycle.
//  - pop  = if_valid & if_ready.
//  - push = (state==FETCH) & ~redirect_valid & (count<FIFO_DEPTH | pop).
//    - Writes {fetch_pc, imem_instr} to the tail.
//    - fetch_pc <= fetch_pc+4, wrapping mod 2^XLEN.
//  - Redirect has absolute priority over push and pop:
//    - FIFO is flushed: count=0, any pop that cycle is discarded.
//    - fetch_pc <= {redirect_pc[XLEN-1:2],2'b00}.
//    - if_valid=0 the next cycle; the first target instruction is valid 2 cycles after the redirect cycle.
//  - Latency: first instruction is valid the cycle after rst_n deassertion.
//  - Throughput: 1 instr/cycle sustained while if_ready=1.
//  - FIFO outputs (if_valid/if_instr/if_pc) are driven from registers, with no combinational path from imem_instr.
//  - When the FIFO is empty: if_instr=NOP, if_pc=0.
//  - FSM states: FETCH, STALL, HALT. Transitions each cycle, checked in this order:
//    - halt=1 -> HALT.
//    - else if FIFO full & ~pop & ~redirect_valid -> STALL.
//    - else -> FETCH.
//  - HALT: no pushes, fetch_pc frozen, FIFO drains normally through pop. A redirect while in HALT still updates fetch_pc and flushes the FIFO.
//  - Boundaries:
//    - full+pop in the same cycle: push and pop both occur, count unchanged.
//    - empty+push: count becomes 1, no bypass.
//    - count never exceeds FIFO_DEPTH; pop when empty is impossible (if_valid=0).
//  - Reset asserted mid-operation clears all state immediately, regardless of clk.
// CONFIGURATION
//  - Macro FETCH_PERF_CNT_EN.
//  - Defined: adds out ports perf_fetch_cnt[63:0] and perf_stall_cnt[63:0], both reset to 0.
//    - perf_fetch_cnt increments on every push.
//    - perf_stall_cnt increments every cycle state==STALL.
//    - Both counters wrap at 2^64 and are not cleared by redirect.
//  - Undefined: neither the ports nor the counters exist; all other behaviour is identical.
// STRUCTURE
//  - Package fetch_pkg:
//    - fetch_entry_t struct {pc[XLEN-1:0], instr[31:0]}.
//    - fetch_state_e enum {FETCH=2'd0, STALL=2'd1, HALT=2'd2}.
//    - Constant NOP_INSTR=32'h00000013.
//  - Sub-module fetch_fifo: parameterised FIFO of fetch_entry_t with push/pop/flush, count, full, empty.
//    - flush overrides push and pop.
//  - fetch_ctrl itself holds the PC register, FSM and push/pop control.
// TESTING
//  - Reset release, if_ready=1, memory holds word i = 0x100+i -> if_pc 0,4,8,... with if_instr 0x100,0x101,... one per cycle.
//  - if_ready=0 for 5 cycles from reset:
//    - FIFO fills to 2; fetch_state=STALL; imem_addr holds 8.
//    - Raising if_ready yields pc 0,4,8 in order, with no loss or duplication.
//  - Redirect to 0x43 while 2 entries are buffered and if_ready=1:
//    - Next cycle if_valid=0, imem_addr=0x40.
//    - Following cycle if_pc=0x40; no old entry is ever popped after the redirect.
//  - halt=1 with 2 buffered entries, if_ready=1: two entries drain, then if_valid=0; imem_addr stays constant; halt=0 resumes from the frozen PC.
//  - Wrap-around: redirect to 64'hFFFF_FFFF_FFFF_FFFC -> entries with pc ...FFFC then 0.
//  - rst_n pulsed low between clock edges mid-stream: outputs return to reset values immediately; FETCH_PERF_CNT_EN build shows both counters at 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the IF-stage fetch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  localparam int FETCH_XLEN = 64;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [31:0]           instr;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    STALL = 2'd1,
    HALT  = 2'd2
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module      : fetch_fifo
// Description : Small register-based FIFO of {pc, instr} fetch entries with
//               push/pop/flush; flush overrides push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  fetch_entry_t               wr_entry,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t       r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_do_push;
  logic               w_do_pop;

  assign full  = (r_count == CNT_W'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  // Guards keep the FIFO self-consistent even if the caller misbehaves.
  assign w_do_push = push & (~full | pop);
  assign w_do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= wr_entry;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module      : fetch_ctrl
// Description : IF-stage fetch sequencer: owns the fetch PC, buffers fetched
//               {pc, instr} pairs and hands them to decode via valid/ready.
//               Optional macro FETCH_PERF_CNT_EN adds fetch/stall counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              XLEN       = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_instr,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            halt,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [1:0]      fetch_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [63:0]     perf_fetch_cnt,
  output logic [63:0]     perf_stall_cnt
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] ST_FETCH = FETCH;
  localparam logic [1:0] ST_STALL = STALL;
  localparam logic [1:0] ST_HALT  = HALT;

  logic [XLEN-1:0]  r_fetch_pc;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [CNT_W-1:0] w_count;
  fetch_entry_t     w_wr_entry;
  fetch_entry_t     w_head;

  assign imem_addr   = r_fetch_pc;
  assign fetch_state = r_state;

  assign w_pop  = if_valid & if_ready;
  assign w_push = (r_state == ST_FETCH) & ~redirect_valid
                & ((w_count < CNT_W'(FIFO_DEPTH)) | w_pop);

  assign w_wr_entry = '{pc: r_fetch_pc, instr: imem_instr};

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (w_push),
    .wr_entry (w_wr_entry),
    .pop      (w_pop),
    .flush    (redirect_valid),
    .head     (w_head),
    .count    (w_count),
    .full     (w_full),
    .empty    (w_empty)
  );

  // Head is a mux of registered FIFO storage; imem_instr never reaches it combinationally.
  assign if_valid = ~w_empty;
  assign if_instr = w_empty ? NOP_INSTR : w_head.instr;
  assign if_pc    = w_empty ? '0 : w_head.pc;

  always_comb begin
    w_state_nxt = ST_FETCH;
    if (halt) begin
      w_state_nxt = ST_HALT;
    end else if (w_full & ~w_pop & ~redirect_valid) begin
      w_state_nxt = ST_STALL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_FETCH;
      r_fetch_pc <= RESET_PC;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[XLEN-1:2], 2'b00};
      end else if (w_push) begin
        r_fetch_pc <= r_fetch_pc + XLEN'(4);
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (w_push) begin
        perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      end
      if (r_state == ST_STALL) begin
        perf_stall_cnt <= perf_stall_cnt + 64'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl with a popped-entry
//               scoreboard; covers FETCH_PERF_CNT_EN builds as well.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic [63:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        halt;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [63:0] if_pc;
  logic [1:0]  fetch_state;
`ifdef FETCH_PERF_CNT_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  fetch_ctrl u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fetch_state    (fetch_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'h100 + a[33:2];
  endfunction

  assign imem_instr = mem_word(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [63:0] pc);
    sb.push_back('{pc: pc, instr: mem_word(pc)});
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    tick();
    rst_n          = 1'b0;
    if_ready       = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    sb.delete();
    tick();
    rst_n = 1'b1;
  endtask

  // A pop happens at the next rising edge unless a redirect discards it.
  always @(negedge clk) begin
    if (rst_n && if_valid && if_ready && !redirect_valid && sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk("pop_pc", if_pc, mon_e.pc);
      chk("pop_instr", {32'b0, if_instr}, {32'b0, mon_e.instr});
    end
  end

  initial begin
    rst_n          = 1'b0;
    if_ready       = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;

    @(negedge clk);
    chk("rst_valid", {63'b0, if_valid}, 64'd0);
    chk("rst_instr", {32'b0, if_instr}, 64'h13);
    chk("rst_pc", if_pc, 64'd0);
    chk("rst_state", {62'b0, fetch_state}, 64'd0);
    chk("rst_addr", imem_addr, 64'd0);

    // Streaming: one instruction per cycle from reset.
    do_reset();
    if_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_exp(64'(4 * i));
    @(negedge clk);
    chk("t1_pre_valid", {63'b0, if_valid}, 64'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("t1_valid", {63'b0, if_valid}, 64'd1);
    end
    tick();
    chk("t1_drained", 64'(sb.size()), 64'd0);

    // Back-pressure: fill, stall, then release.
    do_reset();
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t2_state", {62'b0, fetch_state}, 64'd1);
    chk("t2_addr", imem_addr, 64'd8);
    chk("t2_head", if_pc, 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("t2_perf_fetch", perf_fetch_cnt, 64'd2);
    chk("t2_perf_stall", perf_stall_cnt, 64'd2);
`endif
    tick();
    push_exp(64'd0);
    push_exp(64'd4);
    push_exp(64'd8);
    if_ready = 1'b1;
    repeat (3) @(negedge clk);
    tick();
    chk("t2_drained", 64'(sb.size()), 64'd0);
    chk("t2_state_run", {62'b0, fetch_state}, 64'd0);

    // Redirect flushes buffered entries.
    do_reset();
    tick();
    tick();
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'h43;
    push_exp(64'h40);
    push_exp(64'h44);
    push_exp(64'h48);
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t3_valid", {63'b0, if_valid}, 64'd0);
    chk("t3_addr", imem_addr, 64'h40);
    @(negedge clk);
    chk("t3_pc", if_pc, 64'h40);
    repeat (2) @(negedge clk);
    tick();
    chk("t3_drained", 64'(sb.size()), 64'd0);

    // Halt drains the buffer and freezes the PC.
    do_reset();
    tick();
    halt = 1'b1;
    tick();
    if_ready = 1'b1;
    push_exp(64'd0);
    push_exp(64'd4);
    @(negedge clk);
    chk("t4_state", {62'b0, fetch_state}, 64'd2);
    @(negedge clk);
    @(negedge clk);
    chk("t4_valid", {63'b0, if_valid}, 64'd0);
    chk("t4_addr", imem_addr, 64'd8);
    repeat (3) @(negedge clk);
    chk("t4_valid_hold", {63'b0, if_valid}, 64'd0);
    chk("t4_addr_hold", imem_addr, 64'd8);
    tick();
    chk("t4_drained", 64'(sb.size()), 64'd0);
    halt = 1'b0;
    push_exp(64'd8);
    push_exp(64'hC);
    repeat (4) @(negedge clk);
    tick();
    chk("t4_resume", 64'(sb.size()), 64'd0);

    // PC wrap-around.
    do_reset();
    if_ready       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
    push_exp(64'hFFFF_FFFF_FFFF_FFFC);
    push_exp(64'd0);
    push_exp(64'd4);
    tick();
    redirect_valid = 1'b0;
    repeat (4) @(negedge clk);
    tick();
    chk("t5_drained", 64'(sb.size()), 64'd0);

    // Asynchronous reset between clock edges.
    do_reset();
    if_ready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    chk("t6_running", {63'b0, if_valid}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_valid", {63'b0, if_valid}, 64'd0);
    chk("t6_instr", {32'b0, if_instr}, 64'h13);
    chk("t6_pc", if_pc, 64'd0);
    chk("t6_addr", imem_addr, 64'd0);
    chk("t6_state", {62'b0, fetch_state}, 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("t6_perf_fetch", perf_fetch_cnt, 64'd0);
    chk("t6_perf_stall", perf_stall_cnt, 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
